// File: rtl/dnn_seq_mlp.sv
// rtl/dnn_seq_mlp.sv - time-multiplexed two-layer MLP with one shared signed MAC, optional hidden ReLU and saturated outputs
module dnn_seq_mlp #(
    parameter int DW    = 5,
    parameter int N_IN  = 4,
    parameter int N_HID = 4,
    parameter int N_OUT = 2,
    parameter int OUT_W = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_IN*DW-1:0]       x_flat,
    input  logic [N_IN*N_HID*DW-1:0] w1_flat,
    input  logic [N_HID*N_OUT*DW-1:0] w2_flat,
    input  logic                     act_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_OUT*OUT_W-1:0]   out_flat,
    output logic [N_OUT-1:0]         out_sat,
    output logic                     busy
);
    localparam int H_W  = 2*DW + $clog2(N_IN);
    localparam int A2_W = H_W + DW + $clog2(N_HID);
    localparam int SW   = (A2_W > OUT_W) ? A2_W : OUT_W;
    localparam int IW   = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int JW   = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int KW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [IW-1:0] I_MAX = IW'(N_IN - 1);
    localparam logic [JW-1:0] J_MAX = JW'(N_HID - 1);
    localparam logic [KW-1:0] K_MAX = KW'(N_OUT - 1);
    localparam logic signed [SW-1:0] OMAX = SW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] OMIN = -OMAX - SW'(1);

    typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;
    state_t state_q, state_d;

    logic [IW-1:0] i_cnt;
    logic [JW-1:0] j_cnt;
    logic [KW-1:0] k_cnt;
    logic signed [DW-1:0]  x_r  [N_IN];
    logic signed [DW-1:0]  w1_r [N_IN][N_HID];
    logic signed [DW-1:0]  w2_r [N_HID][N_OUT];
    logic                  act_r;
    logic signed [H_W-1:0] acc;
    logic signed [H_W-1:0] h_r  [N_HID];
    logic signed [A2_W-1:0] acc2;
    logic [N_OUT*OUT_W-1:0] out_q;
    logic [N_OUT-1:0]       sat_q;

    logic i_last, j_last, k_last;
    logic signed [2*DW-1:0]   prod1;
    logic signed [H_W-1:0]    l1_sum, h_val;
    logic signed [H_W+DW-1:0] prod2;
    logic signed [A2_W-1:0]   l2_sum;
    logic signed [SW-1:0]     sum_ext;
    logic                     sat_hi, sat_lo;
    logic [OUT_W-1:0]         sat_val;

    assign i_last = (i_cnt == I_MAX);
    assign j_last = (j_cnt == J_MAX);
    assign k_last = (k_cnt == K_MAX);

    // j_cnt is the outer index in layer 1 and the inner index in layer 2
    assign prod1   = x_r[i_cnt] * w1_r[i_cnt][j_cnt];
    assign l1_sum  = acc + H_W'(prod1);
    assign h_val   = (act_r && l1_sum[H_W-1]) ? '0 : l1_sum;
    assign prod2   = h_r[j_cnt] * w2_r[j_cnt][k_cnt];
    assign l2_sum  = acc2 + A2_W'(prod2);
    assign sum_ext = SW'(l2_sum);
    assign sat_hi  = sum_ext > OMAX;
    assign sat_lo  = sum_ext < OMIN;
    assign sat_val = sat_hi ? OMAX[OUT_W-1:0] : (sat_lo ? OMIN[OUT_W-1:0] : sum_ext[OUT_W-1:0]);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_flat  = out_q;
    assign out_sat   = sat_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = L1;
            L1:      if (i_last && j_last) state_d = L2;
            L2:      if (j_last && k_last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_cnt   <= '0;
            j_cnt   <= '0;
            k_cnt   <= '0;
            acc     <= '0;
            acc2    <= '0;
            act_r   <= 1'b0;
            out_q   <= '0;
            sat_q   <= '0;
            for (int i = 0; i < N_IN; i++) begin
                x_r[i] <= '0;
                for (int j = 0; j < N_HID; j++) w1_r[i][j] <= '0;
            end
            for (int j = 0; j < N_HID; j++) begin
                h_r[j] <= '0;
                for (int k = 0; k < N_OUT; k++) w2_r[j][k] <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (in_valid) begin
                    act_r <= act_sel;
                    for (int i = 0; i < N_IN; i++) begin
                        x_r[i] <= x_flat[i*DW +: DW];
                        for (int j = 0; j < N_HID; j++)
                            w1_r[i][j] <= w1_flat[(i*N_HID+j)*DW +: DW];
                    end
                    for (int j = 0; j < N_HID; j++)
                        for (int k = 0; k < N_OUT; k++)
                            w2_r[j][k] <= w2_flat[(j*N_OUT+k)*DW +: DW];
                end
                L1: begin
                    i_cnt <= i_last ? '0 : i_cnt + IW'(1);
                    if (i_last) begin
                        acc        <= '0;
                        h_r[j_cnt] <= h_val;
                        j_cnt      <= j_last ? '0 : j_cnt + JW'(1);
                    end else begin
                        acc <= l1_sum;
                    end
                end
                L2: begin
                    j_cnt <= j_last ? '0 : j_cnt + JW'(1);
                    if (j_last) begin
                        acc2                         <= '0;
                        out_q[k_cnt*OUT_W +: OUT_W]  <= sat_val;
                        sat_q[k_cnt]                 <= sat_hi | sat_lo;
                        k_cnt                        <= k_last ? '0 : k_cnt + KW'(1);
                    end else begin
                        acc2 <= l2_sum;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/dnn_seq_mlp.md
Name: dnn_seq_mlp

Overview:
Parametrised, time-multiplexed two-layer MLP (N_IN inputs -> N_HID hidden -> N_OUT outputs). It is the successor to the fixed 4-4-2 dnn_top. A single signed MAC is reused across both layers, and the hidden layer has an optional ReLU. Outputs saturate to OUT_W bits. Valid/ready handshakes on input and output let it sit between a weight/feature streamer and the downstream accumulator.

Parameters:
DW, 5, signed width of every input x and weight.
N_IN, 4, number of inputs.
N_HID, 4, number of hidden neurons.
N_OUT, 2, number of outputs.
OUT_W, 17, signed output width; results saturate to this width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  batch present on x_flat/w1_flat/w2_flat/act_sel.
in_ready  out  1  block can accept a batch.
x_flat  in  N_IN*DW  x[i] at bits [i*DW +: DW].
w1_flat  in  N_IN*N_HID*DW  w1[i][j] at bits [(i*N_HID+j)*DW +: DW].
w2_flat  in  N_HID*N_OUT*DW  w2[j][k] at bits [(j*N_OUT+k)*DW +: DW].
act_sel  in  1  0 = identity on the hidden layer, 1 = ReLU on the hidden layer.
out_valid  out  1  results valid.
out_ready  in  1  consumer accepts results.
out_flat  out  N_OUT*OUT_W  out[k] at bits [k*OUT_W +: OUT_W].
out_sat  out  N_OUT  bit k is 1 when out[k] was clipped.
busy  out  1  state is not IDLE.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - State goes to IDLE.
  - out_valid=0, out_flat=0, out_sat=0, busy=0.
  - Accumulator, counters and hidden registers are cleared.
  - in_ready=1 from the first cycle after deassert.
- FSM states: IDLE, L1, L2, DONE.
- in_ready=1 only in IDLE. The accept edge is the edge with in_valid&&in_ready.
  - On accept, x, w1, w2 and act_sel are snapshotted into internal registers. Later input changes have no effect.
  - State goes IDLE->L1.
  - in_valid in any other state is ignored.
- L1: one MAC per cycle, order j outer (0..N_HID-1), i inner (0..N_IN-1).
  - acc += x[i]*w1[i][j].
  - On i==N_IN-1: h[j] = act(acc+product) and acc clears.
  - After j==N_HID-1, go to L2.
  - Width rules: product is 2*DW bits signed; h is H_W = 2*DW+clog2(N_IN) bits signed, full precision, no clipping.
  - ReLU maps negative values to 0.
- L2: one MAC per cycle, order k outer, j inner.
  - acc2 += h[j]*w2[j][k], with full width H_W+DW+clog2(N_HID).
  - On j==N_HID-1, the result saturates to the signed OUT_W range, is written to out[k], sets out_sat[k] if clipped, and acc2 clears.
  - After k==N_OUT-1, go to DONE.
- Latency: L1 takes N_IN*N_HID cycles and L2 takes N_HID*N_OUT cycles. out_valid rises N_IN*N_HID+N_HID*N_OUT cycles after the accept edge (24 for defaults).
- DONE: out_valid=1, and out_flat/out_sat are held stable until out_valid&&out_ready.
  - On that edge, out_valid goes to 0 and the state goes to IDLE.
  - out_flat/out_sat keep their last values until overwritten by the next batch.
- Back-to-back: with in_valid held high and out_ready=1, the accept period is latency+2 cycles.
- Reset mid-operation: the batch is abandoned, no out_valid is produced, and all outputs return to reset values.
- Boundary: exact range limits (-2^(OUT_W-1), 2^(OUT_W-1)-1) are not flagged as saturated.
- N_IN, N_HID, N_OUT must each be >= 1. With a value of 1, the corresponding counter's inner and outer end conditions coincide.

Test Plan:
1. Defaults, all x=w1=w2=1, act_sel=0 -> h=4, out0=out1=16, out_sat=0, out_valid exactly 24 cycles after accept.
2. x=1, w1=-1 (5'h1f), w2=1 -> act_sel=0 gives out0=out1=-16; act_sel=1 gives out0=out1=0.
3. Defaults, x=w1=w2=-16 -> h=1024, out=-65536, out_sat=0. Separate instance with OUT_W=12, x=w1=w2=7 -> raw 5488, out=2047, out_sat=2'b11.
4. out_ready held 0 for 10 cycles after out_valid -> out_valid and out_flat stable, in_ready=0, a second in_valid is ignored. Raise out_ready -> in_ready=1 the next cycle and the new batch is accepted.
5. Assert rst_n=0 during L2 -> out_valid=0, busy=0, in_ready=1 after release. Rerun scenario 1 and it yields 16/16.
6. Change x_flat/w1_flat every cycle after accept -> result matches the snapshot values. 20 random back-to-back batches match a golden model; the accept period is 26 cycles.
